// File: rtl/gmii_tx_arbiter.sv
// ---------------------------------------------------------------------------
// gmii_tx_arbiter
//   Shares one GMII transmit path between two byte-stream frame sources.
//   Round-robin arbitration at frame boundaries, preamble/SFD insertion,
//   inter-frame gap enforcement and underrun signalling on gmii_tx_er.
//   Single clock domain (GMII TX clock), synchronous active-high reset.
//
//   Optional feature macro: GMII_TX_ARB_PAD_EN
//     defined   -> short frames are padded with 0x00 up to MIN_FRAME_LEN
//     undefined -> no padding; last byte goes straight to the gap
// ---------------------------------------------------------------------------
module gmii_tx_arbiter #(
    parameter int unsigned PREAMBLE_LEN  = 7,
    parameter int unsigned IFG_LEN       = 12
`ifdef GMII_TX_ARB_PAD_EN
    ,
    parameter int unsigned MIN_FRAME_LEN = 60
`endif
) (
    input  logic       clk,
    input  logic       rst,

    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_last,
    output logic       s0_ready,

    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_last,
    output logic       s1_ready,

    output logic [7:0] gmii_tx_data,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       grant,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_SFD   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_IFG   = 3'd5;

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    // One shared cycle counter serves the preamble and the gap.
    localparam int unsigned CNT_MAX = (PREAMBLE_LEN > IFG_LEN) ? PREAMBLE_LEN : IFG_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_LEN - 1);

`ifdef GMII_TX_ARB_PAD_EN
    localparam logic [2:0]  ST_PAD  = 3'd6;
    localparam int unsigned BCNT_W  = 16;
    localparam logic [BCNT_W-1:0] MIN_LEN  = BCNT_W'(MIN_FRAME_LEN);
    localparam logic [BCNT_W-1:0] BCNT_SAT = {BCNT_W{1'b1}};

    // Data+pad byte count of the frame in flight; only the pad decision reads it.
    logic [BCNT_W-1:0] byte_cnt;
    logic [BCNT_W-1:0] byte_cnt_d;
    logic [BCNT_W-1:0] byte_cnt_inc;
`endif

    logic [2:0]       state;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             grant_d;
    logic             rr;
    logic             rr_d;
    logic [7:0]       data_d;
    logic             en_d;
    logic             er_d;
    logic             busy_d;

    logic [7:0]       sel_data;
    logic             sel_valid;
    logic             sel_last;

    // Mux the granted source's stream.
    always_comb begin
        sel_data  = grant ? s1_data  : s0_data;
        sel_valid = grant ? s1_valid : s0_valid;
        sel_last  = grant ? s1_last  : s0_last;
    end

    // Only the granted source is accepted, and only while taking or draining bytes.
    always_comb begin
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        if (state == ST_DATA || state == ST_DRAIN) begin
            s0_ready = ~grant;
            s1_ready = grant;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        grant_d = grant;
        rr_d    = rr;
        data_d  = 8'h00;
        en_d    = 1'b0;
        er_d    = 1'b0;
`ifdef GMII_TX_ARB_PAD_EN
        byte_cnt_d   = byte_cnt;
        byte_cnt_inc = (byte_cnt == BCNT_SAT) ? byte_cnt : byte_cnt + BCNT_W'(1);
`endif

        case (state)
            ST_IDLE: begin
                cnt_d = '0;
`ifdef GMII_TX_ARB_PAD_EN
                byte_cnt_d = '0;
`endif
                if (s0_valid || s1_valid) begin
                    grant_d = (s0_valid && s1_valid) ? rr : s1_valid;
                    rr_d    = ~grant_d;
                    state_d = ST_PRE;
                end
            end

            ST_PRE: begin
                data_d = PRE_BYTE;
                en_d   = 1'b1;
                if (cnt == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SFD;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            ST_SFD: begin
                data_d  = SFD_BYTE;
                en_d    = 1'b1;
                state_d = ST_DATA;
            end

            ST_DATA: begin
                en_d = 1'b1;
                if (sel_valid) begin
                    data_d = sel_data;
`ifdef GMII_TX_ARB_PAD_EN
                    byte_cnt_d = byte_cnt_inc;
`endif
                    if (sel_last) begin
                        cnt_d = '0;
`ifdef GMII_TX_ARB_PAD_EN
                        state_d = (byte_cnt_inc < MIN_LEN) ? ST_PAD : ST_IFG;
`else
                        state_d = ST_IFG;
`endif
                    end
                end else begin
                    // Source ran dry mid-frame: one error byte, then discard the rest.
                    er_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Line is already idle here, so these cycles count towards the gap.
                if (cnt < IFG_LAST) begin
                    cnt_d = cnt + CNT_W'(1);
                end
                if (sel_valid && sel_last) begin
                    state_d = ST_IFG;
                end
            end

            ST_IFG: begin
                if (cnt >= IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

`ifdef GMII_TX_ARB_PAD_EN
            ST_PAD: begin
                en_d       = 1'b1;
                byte_cnt_d = byte_cnt_inc;
                if (byte_cnt_inc >= MIN_LEN) begin
                    cnt_d   = '0;
                    state_d = ST_IFG;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered GMII outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            grant        <= 1'b0;
            rr           <= 1'b0;
            gmii_tx_data <= 8'h00;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            busy         <= 1'b0;
`ifdef GMII_TX_ARB_PAD_EN
            byte_cnt     <= '0;
`endif
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            grant        <= grant_d;
            rr           <= rr_d;
            gmii_tx_data <= data_d;
            gmii_tx_en   <= en_d;
            gmii_tx_er   <= er_d;
            busy         <= busy_d;
`ifdef GMII_TX_ARB_PAD_EN
            byte_cnt     <= byte_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gmii_tx_arbiter
//   Directed bench for gmii_tx_arbiter. Sources are queue-driven byte
//   streams; the GMII side is captured frame by frame and compared with
//   hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_gmii_tx_arbiter;

    localparam int CLK_HALF = 5;
    localparam int HDR      = 8;     // 7 preamble bytes + SFD
    localparam int GAP      = 13;    // IFG_LEN + 1 en-low cycles
    localparam int BUDGET   = 2000;
`ifdef GMII_TX_ARB_PAD_EN
    localparam int PAD_MIN  = 60;
`else
    localparam int PAD_MIN  = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s0_data  = 8'h00;
    logic       s0_valid = 1'b0;
    logic       s0_last  = 1'b0;
    logic       s0_ready;
    logic [7:0] s1_data  = 8'h00;
    logic       s1_valid = 1'b0;
    logic       s1_last  = 1'b0;
    logic       s1_ready;
    logic [7:0] gmii_tx_data;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       grant;
    logic       busy;

    always #CLK_HALF clk = ~clk;

    gmii_tx_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .s0_data      (s0_data),
        .s0_valid     (s0_valid),
        .s0_last      (s0_last),
        .s0_ready     (s0_ready),
        .s1_data      (s1_data),
        .s1_valid     (s1_valid),
        .s1_last      (s1_last),
        .s1_ready     (s1_ready),
        .gmii_tx_data (gmii_tx_data),
        .gmii_tx_en   (gmii_tx_en),
        .gmii_tx_er   (gmii_tx_er),
        .grant        (grant),
        .busy         (busy)
    );

    // Pending source bytes: {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       hs0 = 1'b0;
    logic       hs1 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] cap_q[$];
    int         cap_low;
    int         cap_er;
    int         cap_er_idx;
    int         cap_er_low;
    logic       cap_grant;

    // Source model: sample handshakes mid-cycle, update streams just after the edge.
    initial begin
        logic [8:0] head;
        forever begin
            @(negedge clk);
            hs0 = s0_valid && s0_ready;
            hs1 = s1_valid && s1_ready;
            @(posedge clk);
            #1;
            if (hs0 && q0.size() > 0) void'(q0.pop_front());
            if (hs1 && q1.size() > 0) void'(q1.pop_front());
            head     = (q0.size() > 0) ? q0[0] : 9'h000;
            s0_valid = (q0.size() > 0);
            s0_data  = head[7:0];
            s0_last  = head[8];
            head     = (q1.size() > 0) ? q1[0] : 9'h000;
            s1_valid = (q1.size() > 0);
            s1_data  = head[7:0];
            s1_last  = head[8];
        end
    end

    // Hard stop in case a bounded wait is somehow bypassed.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input int n);
        return HDR + ((n > PAD_MIN) ? n : PAD_MIN);
    endfunction

    // Starting at a negedge: count en-low cycles, then record one en-high burst.
    task automatic capture_frame(input string tag);
        int guard;
        guard      = 0;
        cap_q.delete();
        cap_low    = 0;
        cap_er     = 0;
        cap_er_idx = -1;
        cap_er_low = 0;
        while (gmii_tx_en !== 1'b1 && guard < BUDGET) begin
            if (gmii_tx_er !== 1'b0) cap_er_low++;
            cap_low++;
            guard++;
            @(negedge clk);
        end
        check({tag, "_start"}, 32'(guard < BUDGET), 32'd1);
        cap_grant = grant;
        while (gmii_tx_en === 1'b1 && guard < BUDGET) begin
            if (gmii_tx_er === 1'b1) begin
                cap_er++;
                cap_er_idx = cap_q.size();
            end
            cap_q.push_back(gmii_tx_data);
            guard++;
            @(negedge clk);
        end
        check({tag, "_end"}, 32'(guard < BUDGET), 32'd1);
    endtask

    task automatic check_hdr(input string tag);
        for (int i = 0; i < 7; i++) check({tag, "_pre"}, 32'(cap_q[i]), 32'h55);
        check({tag, "_sfd"}, 32'(cap_q[7]), 32'hD5);
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (busy !== 1'b0 && guard < BUDGET) begin
            guard++;
            @(negedge clk);
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n_hi;
        int n_er;
        int n_nz;
        int guard;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",  32'(gmii_tx_data), 32'h00);
        check("rst_en",    32'(gmii_tx_en),   32'd0);
        check("rst_er",    32'(gmii_tx_er),   32'd0);
        check("rst_ready", 32'({s0_ready, s1_ready}), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        rst = 1'b0;

        // 1: single 3-byte frame from s0
        q0.push_back({1'b0, 8'hA1});
        q0.push_back({1'b0, 8'hA2});
        q0.push_back({1'b1, 8'hA3});
        capture_frame("t1");
        check("t1_len", 32'(cap_q.size()), 32'(frame_len(3)));
        check_hdr("t1");
        check("t1_b0", 32'(cap_q[8]),  32'hA1);
        check("t1_b1", 32'(cap_q[9]),  32'hA2);
        check("t1_b2", 32'(cap_q[10]), 32'hA3);
        check("t1_er", 32'(cap_er + cap_er_low), 32'd0);
        check("t1_grant", 32'(cap_grant), 32'd0);
        wait_idle("t1_idle");

        // 2: both sources request in the same idle cycle after reset
        do_reset(2);
        q0.push_back({1'b0, 8'hB1});
        q0.push_back({1'b1, 8'hB2});
        q1.push_back({1'b0, 8'hC1});
        q1.push_back({1'b0, 8'hC2});
        q1.push_back({1'b1, 8'hC3});
        capture_frame("t2a");
        check("t2a_grant", 32'(cap_grant), 32'd0);
        check("t2a_len",   32'(cap_q.size()), 32'(frame_len(2)));
        check("t2a_b0",    32'(cap_q[8]), 32'hB1);
        capture_frame("t2b");
        check("t2b_gap",   32'(cap_low), 32'(GAP));
        check("t2b_grant", 32'(cap_grant), 32'd1);
        check("t2b_len",   32'(cap_q.size()), 32'(frame_len(3)));
        check_hdr("t2b");
        check("t2b_b0",    32'(cap_q[8]),  32'hC1);
        check("t2b_b2",    32'(cap_q[10]), 32'hC3);
        check("t2b_er",    32'(cap_er + cap_er_low), 32'd0);
        wait_idle("t2_idle");

        // 3: s1 underruns after two bytes, then finishes its frame late
        q1.push_back({1'b0, 8'hD1});
        q1.push_back({1'b0, 8'hD2});
        capture_frame("t3");
        check("t3_len",    32'(cap_q.size()), 32'd11);
        check("t3_grant",  32'(cap_grant), 32'd1);
        check("t3_b1",     32'(cap_q[9]),  32'hD2);
        check("t3_errdat", 32'(cap_q[10]), 32'h00);
        check("t3_ercnt",  32'(cap_er), 32'd1);
        check("t3_eridx",  32'(cap_er_idx), 32'd10);
        check("t3_busy",   32'(busy), 32'd1);
        check("t3_ready",  32'({s0_ready, s1_ready}), 32'b01);
        q1.push_back({1'b0, 8'hE1});
        q1.push_back({1'b0, 8'hE2});
        q1.push_back({1'b1, 8'hE3});
        n_hi  = 0;
        n_er  = 0;
        guard = 0;
        while (busy !== 1'b0 && guard < BUDGET) begin
            if (gmii_tx_en !== 1'b0) n_hi++;
            if (gmii_tx_er !== 1'b0) n_er++;
            guard++;
            @(negedge clk);
        end
        check("t3_drain_en", 32'(n_hi), 32'd0);
        check("t3_drain_er", 32'(n_er), 32'd0);
        check("t3_consumed", 32'(q1.size()), 32'd0);
        check("t3_idle",     32'(busy), 32'd0);

        // 4: short frame, padded only when the pad feature is built in
        q0.push_back({1'b0, 8'hA1});
        q0.push_back({1'b0, 8'hA2});
        q0.push_back({1'b1, 8'hA3});
        capture_frame("t4");
        check("t4_len", 32'(cap_q.size()), 32'(frame_len(3)));
        check("t4_b2",  32'(cap_q[10]), 32'hA3);
        n_nz = 0;
        for (int i = 11; i < cap_q.size(); i++) if (cap_q[i] !== 8'h00) n_nz++;
        check("t4_pad_zero", 32'(n_nz), 32'd0);
        check("t4_er", 32'(cap_er + cap_er_low), 32'd0);
        wait_idle("t4_idle");

        // 5: reset mid-frame, then rr pointer must be back on s0
        q0.push_back({1'b0, 8'hF1});
        q0.push_back({1'b0, 8'hF2});
        q0.push_back({1'b0, 8'hF3});
        q0.push_back({1'b0, 8'hF4});
        q0.push_back({1'b0, 8'hF5});
        q0.push_back({1'b1, 8'hF6});
        guard = 0;
        while (!(gmii_tx_en === 1'b1 && gmii_tx_data === 8'hF1) && guard < BUDGET) begin
            guard++;
            @(negedge clk);
        end
        check("t5_in_data", 32'(guard < BUDGET), 32'd1);
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        check("t5_en",    32'(gmii_tx_en),   32'd0);
        check("t5_er",    32'(gmii_tx_er),   32'd0);
        check("t5_data",  32'(gmii_tx_data), 32'h00);
        check("t5_ready", 32'({s0_ready, s1_ready}), 32'd0);
        check("t5_busy",  32'(busy), 32'd0);
        rst = 1'b0;
        q0.push_back({1'b1, 8'h4B});
        q1.push_back({1'b1, 8'h4C});
        capture_frame("t5a");
        check("t5a_grant", 32'(cap_grant), 32'd0);
        check("t5a_b0",    32'(cap_q[8]), 32'h4B);
        capture_frame("t5b");
        check("t5b_grant", 32'(cap_grant), 32'd1);
        check("t5b_b0",    32'(cap_q[8]), 32'h4C);
        check("t5b_gap",   32'(cap_low), 32'(GAP));
        wait_idle("t5_idle");

        // 6: s0 streams back-to-back frames (including 1-byte frames)
        q0.push_back({1'b1, 8'h61});
        q0.push_back({1'b0, 8'h71});
        q0.push_back({1'b1, 8'h72});
        q0.push_back({1'b1, 8'h81});
        capture_frame("t6a");
        check("t6a_grant", 32'(cap_grant), 32'd0);
        check("t6a_len",   32'(cap_q.size()), 32'(frame_len(1)));
        check("t6a_b0",    32'(cap_q[8]), 32'h61);
        capture_frame("t6b");
        check("t6b_gap",   32'(cap_low), 32'(GAP));
        check("t6b_grant", 32'(cap_grant), 32'd0);
        check("t6b_len",   32'(cap_q.size()), 32'(frame_len(2)));
        check("t6b_b1",    32'(cap_q[9]), 32'h72);
        capture_frame("t6c");
        check("t6c_gap",   32'(cap_low), 32'(GAP));
        check("t6c_grant", 32'(cap_grant), 32'd0);
        check("t6c_b0",    32'(cap_q[8]), 32'h81);
        wait_idle("t6_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
